// File: rtl/clkgate_multi_idle_if.sv
// clkgate_multi_idle_if: channel bundle for the multi-channel idle-hysteresis clock gate
// Signals: E requests, SE scan enable, IDLE_TH threshold (master drives); GCK gated clocks, GATED status (slave drives)
// Macro CLKGATE_STATS_EN adds GCYC, the all-gated cycle counter
interface clkgate_multi_idle_if #(
  parameter int NCH = 4,
  parameter int IDLE_W = 4
`ifdef CLKGATE_STATS_EN
  , parameter int CNT_W = 16
`endif
);
  logic [NCH-1:0] E;
  logic SE;
  logic [IDLE_W-1:0] IDLE_TH;
  logic [NCH-1:0] GCK;
  logic [NCH-1:0] GATED;
`ifdef CLKGATE_STATS_EN
  logic [CNT_W-1:0] GCYC;
  modport master (output E, SE, IDLE_TH, input GCK, GATED, GCYC);
  modport slave (input E, SE, IDLE_TH, output GCK, GATED, GCYC);
`else
  modport master (output E, SE, IDLE_TH, input GCK, GATED);
  modport slave (input E, SE, IDLE_TH, output GCK, GATED);
`endif
endinterface

// File: rtl/clkgate_multi_idle.sv
// clkgate_multi_idle: NCH glitch-free clock gates with per-channel idle hysteresis and scan override
// Ports: CK clock, RST sync active-high reset, bus (slave): E, SE, IDLE_TH in; GCK, GATED out
// Macro CLKGATE_STATS_EN adds bus.GCYC, saturating count of edges with every channel gated
module clkgate_multi_idle #(
  parameter int NCH = 4,
  parameter int IDLE_W = 4
`ifdef CLKGATE_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input logic CK,
  input logic RST,
  clkgate_multi_idle_if.slave bus
);
  localparam logic [1:0] S_RUN = 2'b00, S_HOLD = 2'b01, S_GATED = 2'b10;
  localparam logic [IDLE_W-1:0] CMAX = '1;
  logic [NCH-1:0] en, lat_q;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [1:0] st_q, st_d;
    logic [IDLE_W-1:0] cnt_q, cnt_d;
    logic go;
    always_comb begin
      go = st_q[1] | (st_q == S_RUN ? bus.IDLE_TH == '0 : cnt_q >= bus.IDLE_TH);
      st_d = bus.E[i] ? S_RUN : go ? S_GATED : S_HOLD;
      cnt_d = st_d != S_HOLD ? '0 : st_q == S_RUN ? IDLE_W'(1) : cnt_q == CMAX ? cnt_q : cnt_q + 1'b1;
    end
    always_ff @(posedge CK) begin
      if (RST) begin
        st_q <= S_RUN;
        cnt_q <= '0;
      end else begin
        st_q <= st_d;
        cnt_q <= cnt_d;
      end
    end
    // bit 1 of the state is the GATED flag, so status and enable come straight off a flop
    assign en[i] = ~st_q[1];
    assign bus.GATED[i] = st_q[1];
  end
  // low-phase latch keeps GCK glitch-free; SE enters here so it takes effect within the same low phase
  always_latch begin
    if (!CK) lat_q <= en | {NCH{bus.SE}};
  end
  assign bus.GCK = {NCH{CK}} & lat_q;
`ifdef CLKGATE_STATS_EN
  logic [CNT_W-1:0] gcyc_q;
  always_ff @(posedge CK) begin
    if (RST) gcyc_q <= '0;
    else if (&bus.GATED && gcyc_q != '1) gcyc_q <= gcyc_q + 1'b1;
  end
  assign bus.GCYC = gcyc_q;
`endif
endmodule

// File: tb/tb_clkgate_multi_idle.sv
// tb_clkgate_multi_idle: scoreboard bench comparing gated clocks and status against a behavioural model
module tb_clkgate_multi_idle;
  localparam int NCH = 4, IDLE_W = 4, CNT_W = 4;
  typedef struct {
    logic [NCH-1:0] gck;
    logic [NCH-1:0] gated;
    logic [CNT_W-1:0] gcyc;
  } exp_t;
  logic CK = 0;
  logic RST = 1;
  int total = 0, bad = 0;
  exp_t sbq[$];
  int mst[NCH], mcnt[NCH];
  int mcyc;
  clkgate_multi_idle_if #(
    .NCH(NCH),
    .IDLE_W(IDLE_W)
`ifdef CLKGATE_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) bus ();
  clkgate_multi_idle #(
    .NCH(NCH),
    .IDLE_W(IDLE_W)
`ifdef CLKGATE_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .CK(CK),
    .RST(RST),
    .bus(bus)
  );
  always #5 CK = ~CK;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic [NCH-1:0] e, input logic se, input int th);
    exp_t x;
    int ng;
    @(negedge CK);
    RST = r;
    bus.E = e;
    bus.SE = se;
    bus.IDLE_TH = IDLE_W'(th);
    @(posedge CK);
    ng = 0;
    for (int i = 0; i < NCH; i++) begin
      x.gck[i] = (mst[i] != 2) | se;
      if (mst[i] == 2) ng++;
    end
    if (r) mcyc = 0;
    else if (ng == NCH && mcyc < (1 << CNT_W) - 1) mcyc++;
    for (int i = 0; i < NCH; i++) begin
      if (r) begin
        mst[i] = 0;
        mcnt[i] = 0;
      end else if (e[i]) begin
        mst[i] = 0;
        mcnt[i] = 0;
      end else if (mst[i] == 0) begin
        if (th == 0) mst[i] = 2;
        else begin
          mst[i] = 1;
          mcnt[i] = 1;
        end
      end else if (mst[i] == 1) begin
        if (mcnt[i] >= th) mst[i] = 2;
        else if (mcnt[i] < 15) mcnt[i]++;
      end
      x.gated[i] = mst[i] == 2;
    end
    x.gcyc = CNT_W'(mcyc);
    sbq.push_back(x);
    #1;
    x = sbq.pop_front();
    chk("gck", 64'(bus.GCK), 64'(x.gck));
    chk("gated", 64'(bus.GATED), 64'(x.gated));
`ifdef CLKGATE_STATS_EN
    chk("gcyc", 64'(bus.GCYC), 64'(x.gcyc));
`endif
  endtask
  initial begin
    logic [NCH-1:0] re;
    bus.E = '0;
    bus.SE = 0;
    bus.IDLE_TH = '0;
    RST = 1;
    @(posedge CK);
    for (int i = 0; i < NCH; i++) begin
      mst[i] = 0;
      mcnt[i] = 0;
    end
    mcyc = 0;
    #1;
    chk("rst_gated", 64'(bus.GATED), 64'd0);
`ifdef CLKGATE_STATS_EN
    chk("rst_gcyc", 64'(bus.GCYC), 64'd0);
`endif
    step(1, '0, 0, 0);
    repeat (4) step(0, '0, 0, 0);
    step(1, '1, 0, 3);
    repeat (3) step(0, '1, 0, 3);
    repeat (6) step(0, 4'b1110, 0, 3);
    step(0, '1, 0, 4);
    repeat (2) step(0, 4'b1011, 0, 4);
    repeat (3) step(0, '1, 0, 4);
    repeat (7) step(0, 4'b1011, 0, 4);
    repeat (2) step(0, '1, 0, 4);
    repeat (6) step(0, 4'b1101, 0, 10);
    repeat (2) step(0, 4'b1101, 0, 2);
    repeat (22) step(0, '0, 0, 0);
    repeat (3) step(0, '0, 1, 0);
    repeat (2) step(0, '0, 0, 0);
    repeat (2) step(0, 4'b0001, 0, 0);
    step(1, '0, 0, 0);
    repeat (300) begin
      for (int b = 0; b < NCH; b++) re[b] = $urandom_range(0, 3) == 0;
      step($urandom_range(0, 39) == 0, re, $urandom_range(0, 9) == 0, int'($urandom_range(0, 5)));
    end
    chk("sbq_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
